// File: rtl/cpu_loader.sv
// cpu_loader: host-side sequencer for the CPU's external memory ports and run control.
// A session streams prog_len instruction words into instruction memory, releases the
// CPU from reset and enables it for run_cycles cycles, then reads dump_len 64-bit words
// of data memory back out over a valid/ready stream.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start                     begin a session (sampled only in IDLE)
//   prog_len/run_cycles/dump_len  session lengths, latched on start
//   in_valid/in_ready/in_data     instruction word input stream
//   out_valid/out_ready/out_data  data word dump output stream
//   busy, done                not-IDLE flag, one-cycle completion pulse
//   cpu_arst_n, cpu_enable    CPU reset (active low) and clock enable
//   addr_ext/wen_ext/ren_ext/wdata_ext          instruction memory port
//   addr_ext_2/wen_ext_2/ren_ext_2/wdata_ext_2  data memory port
//   rdata_ext_2               data memory read data, one cycle after ren_ext_2
module cpu_loader #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned RUN_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] prog_len,
    input  logic [RUN_W-1:0] run_cycles,
    input  logic [CNT_W-1:0] dump_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic             busy,
    output logic             done,
    output logic             cpu_arst_n,
    output logic             cpu_enable,
    output logic [63:0]      addr_ext,
    output logic             wen_ext,
    output logic             ren_ext,
    output logic [31:0]      wdata_ext,
    output logic [63:0]      addr_ext_2,
    output logic             wen_ext_2,
    output logic             ren_ext_2,
    output logic [63:0]      wdata_ext_2,
    input  logic [63:0]      rdata_ext_2
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRun,
        StDumpReq,
        StDumpWait,
        StDumpOut,
        StDone
    } state_e;

    localparam logic [CNT_W:0] CntOne = {{CNT_W{1'b0}}, 1'b1};
    localparam logic [RUN_W-1:0] RunOne = {{(RUN_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] prog_len_q, prog_len_d;
    logic [CNT_W-1:0] dump_len_q, dump_len_d;
    logic [RUN_W-1:0] run_rem_q, run_rem_d;
    // Word index: counts accepted words in LOAD, then the dump word in DUMP_*.
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W:0]   idx_inc;

    logic             in_ready_q, in_ready_d;
    logic             wen_q, wen_d;
    logic [63:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             ren2_q, ren2_d;
    logic [63:0]      addr2_q, addr2_d;
    logic             out_valid_q, out_valid_d;
    logic [63:0]      out_data_q, out_data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             arst_n_q, arst_n_d;
    logic             en_q, en_d;

    assign idx_inc = {1'b0, idx_q} + CntOne;

    always_comb begin
        state_d     = state_q;
        prog_len_d  = prog_len_q;
        dump_len_d  = dump_len_q;
        run_rem_d   = run_rem_q;
        idx_d       = idx_q;
        in_ready_d  = in_ready_q;
        wen_d       = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        addr2_d     = addr2_q;
        out_data_d  = out_data_q;
        en_d        = en_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    prog_len_d = prog_len;
                    dump_len_d = dump_len;
                    run_rem_d  = run_cycles;
                    idx_d      = '0;
                    if (prog_len == '0) begin
                        state_d = StRun;
                        en_d    = (run_cycles != '0);
                    end else begin
                        state_d    = StLoad;
                        in_ready_d = 1'b1;
                    end
                end
            end
            StLoad: begin
                if (in_ready_q) begin
                    if (in_valid) begin
                        wen_d   = 1'b1;
                        addr_d  = {{(64-CNT_W){1'b0}}, idx_q} << 2;
                        wdata_d = in_data;
                        idx_d   = idx_inc[CNT_W-1:0];
                        if (idx_inc == {1'b0, prog_len_q}) begin
                            in_ready_d = 1'b0;
                        end
                    end
                end else begin
                    // in_ready already low: the final write is on the port this cycle,
                    // so enabling the CPU from the next cycle keeps it strictly ahead.
                    state_d = StRun;
                    en_d    = (run_rem_q != '0);
                end
            end
            StRun: begin
                // run_rem_q counts enabled cycles left including the current one.
                if (run_rem_q > RunOne) begin
                    run_rem_d = run_rem_q - RunOne;
                end else begin
                    en_d  = 1'b0;
                    idx_d = '0;
                    if (dump_len_q == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d = StDumpReq;
                        addr2_d = '0;
                    end
                end
            end
            StDumpReq: begin
                state_d = StDumpWait;
            end
            StDumpWait: begin
                out_data_d = rdata_ext_2;
                state_d    = StDumpOut;
            end
            StDumpOut: begin
                if (out_ready) begin
                    if (idx_inc < {1'b0, dump_len_q}) begin
                        idx_d   = idx_inc[CNT_W-1:0];
                        addr2_d = {{(64-CNT_W-1){1'b0}}, idx_inc} << 3;
                        state_d = StDumpReq;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Status strobes are registered copies of the next state.
        busy_d      = (state_d != StIdle);
        done_d      = (state_d == StDone);
        ren2_d      = (state_d == StDumpReq);
        out_valid_d = (state_d == StDumpOut);
        arst_n_d    = (state_d != StIdle) && (state_d != StLoad);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            prog_len_q  <= '0;
            dump_len_q  <= '0;
            run_rem_q   <= '0;
            idx_q       <= '0;
            in_ready_q  <= 1'b0;
            wen_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            ren2_q      <= 1'b0;
            addr2_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            arst_n_q    <= 1'b0;
            en_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            prog_len_q  <= prog_len_d;
            dump_len_q  <= dump_len_d;
            run_rem_q   <= run_rem_d;
            idx_q       <= idx_d;
            in_ready_q  <= in_ready_d;
            wen_q       <= wen_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ren2_q      <= ren2_d;
            addr2_q     <= addr2_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            arst_n_q    <= arst_n_d;
            en_q        <= en_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign cpu_arst_n  = arst_n_q;
    assign cpu_enable  = en_q;
    assign addr_ext    = addr_q;
    assign wen_ext     = wen_q;
    assign ren_ext     = 1'b0;
    assign wdata_ext   = wdata_q;
    assign addr_ext_2  = addr2_q;
    assign wen_ext_2   = 1'b0;
    assign ren_ext_2   = ren2_q;
    assign wdata_ext_2 = '0;

endmodule

// File: tb/tb_cpu_loader.sv
// Testbench for cpu_loader: directed sessions, expected memory-port events pushed into
// queues at stimulus time and popped by a negedge monitor whenever the DUT strobes.
module tb_cpu_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] prog_len = '0;
    logic [31:0] run_cycles = '0;
    logic [15:0] dump_len = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_data;
    logic        busy, done, cpu_arst_n, cpu_enable;
    logic [63:0] addr_ext, addr_ext_2, wdata_ext_2;
    logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2;
    logic [31:0] wdata_ext;
    logic [63:0] rdata_ext_2 = '0;

    always #5 clk = ~clk;

    cpu_loader #(.CNT_W(16), .RUN_W(32)) dut (
        .clk(clk), .rst(rst), .start(start),
        .prog_len(prog_len), .run_cycles(run_cycles), .dump_len(dump_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done), .cpu_arst_n(cpu_arst_n), .cpu_enable(cpu_enable),
        .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
        .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
        .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2)
    );

    // Data memory model: two words, read data one cycle after ren_ext_2.
    logic [63:0] dmem [2];
    initial begin
        dmem[0] = 64'h1111_2222_3333_4444;
        dmem[1] = 64'hDEAD_BEEF_0123_4567;
    end
    always @(posedge clk) begin
        if (ren_ext_2) rdata_ext_2 <= dmem[addr_ext_2[3]];
    end

    typedef struct {
        logic [63:0] addr;
        logic [31:0] data;
        int          gap;
    } wr_t;

    wr_t         wq[$];
    logic [63:0] rq[$];
    logic [63:0] oq[$];
    logic [31:0] pw[$];
    int          done_exp = 0;
    int          done_cnt = 0;
    int          en_cnt = 0;
    int          cyc = 0;
    int          last_wr_cyc = 0;
    logic        prev_en = 1'b0;
    logic        prev_arst = 1'b0;
    int          vectors = 0;
    int          miscompares = 0;
    wr_t         mon_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every DUT strobe consumes one expected entry.
    always @(negedge clk) begin
        cyc++;
        if (wen_ext) begin
            if (wq.size() == 0) chk("unexpected_write", 64'(1), 64'(0));
            else begin
                mon_e = wq.pop_front();
                chk("wr_addr", addr_ext, mon_e.addr);
                chk("wr_data", 64'(wdata_ext), 64'(mon_e.data));
                if (mon_e.gap > 0) chk("wr_gap", 64'(cyc - last_wr_cyc), 64'(mon_e.gap));
            end
            last_wr_cyc = cyc;
        end
        if (ren_ext_2) begin
            if (rq.size() == 0) chk("unexpected_read", 64'(1), 64'(0));
            else chk("rd_addr", addr_ext_2, rq.pop_front());
        end
        if (out_valid) begin
            if (oq.size() == 0) chk("unexpected_out", 64'(1), 64'(0));
            else begin
                chk("out_data", out_data, oq[0]);
                if (out_ready) void'(oq.pop_front());
            end
        end
        if (done) begin
            done_cnt++;
            if (done_exp == 0) chk("unexpected_done", 64'(1), 64'(0));
            else done_exp--;
        end
        if (cpu_enable) begin
            en_cnt++;
            chk("arst_n_during_enable", 64'(cpu_arst_n), 64'(1));
            chk("write_during_enable", 64'(wen_ext), 64'(0));
            if (!prev_en) chk("arst_n_before_enable", 64'(prev_arst), 64'(0));
        end
        prev_en   = cpu_enable;
        prev_arst = cpu_arst_n;
    end

    task automatic start_session(input int pl, input int rc, input int dl);
        @(posedge clk); #1;
        prog_len   = 16'(pl);
        run_cycles = 32'(rc);
        dump_len   = 16'(dl);
        en_cnt     = 0;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Feed pw[] through the input stream; toggle=1 gives valid 1,0,1,...
    task automatic feed(input bit toggle);
        int i = 0;
        int c = 0;
        logic hs;
        while (i < pw.size() && c < 200) begin
            in_valid = toggle ? (c % 2 == 0) : 1'b1;
            in_data  = pw[i];
            @(negedge clk);
            hs = in_valid & in_ready;
            @(posedge clk); #1;
            if (hs) i++;
            c++;
        end
        if (i < pw.size()) chk("load_timeout", 64'(i), 64'(pw.size()));
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        forever begin
            @(negedge clk);
            if (done) break;
            n++;
            if (n > 500) begin
                chk("done_timeout", 64'(0), 64'(1));
                break;
            end
        end
    endtask

    task automatic finish_session(input int exp_en);
        wait_done();
        chk("enable_cycles", 64'(en_cnt), 64'(exp_en));
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'(0));
        chk("busy_after_done", 64'(busy), 64'(0));
        chk("arst_n_idle", 64'(cpu_arst_n), 64'(0));
        chk("in_ready_idle", 64'(in_ready), 64'(0));
        chk("writes_left", 64'(wq.size()), 64'(0));
        chk("reads_left", 64'(rq.size()), 64'(0));
        chk("outs_left", 64'(oq.size()), 64'(0));
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int dc;
        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_enable", 64'(cpu_enable), 64'(0));
        chk("rst_arst_n", 64'(cpu_arst_n), 64'(0));
        chk("rst_wen", 64'(wen_ext), 64'(0));
        chk("rst_ren2", 64'(ren_ext_2), 64'(0));
        chk("rst_addr", addr_ext, 64'(0));
        chk("rst_wdata", 64'(wdata_ext), 64'(0));
        chk("rst_addr2", addr_ext_2, 64'(0));
        chk("rst_out_data", out_data, 64'(0));
        chk("ren_ext_tie", 64'(ren_ext), 64'(0));
        chk("wen_ext_2_tie", 64'(wen_ext_2), 64'(0));
        chk("wdata_ext_2_tie", wdata_ext_2, 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // Session A: 3 words back to back, 10 run cycles, 2 dump words with a 5-cycle stall.
        pw = '{32'h0000_0013, 32'h0010_0093, 32'h0020_8113};
        wq.push_back('{64'h0, 32'h0000_0013, 0});
        wq.push_back('{64'h4, 32'h0010_0093, 1});
        wq.push_back('{64'h8, 32'h0020_8113, 1});
        rq.push_back(64'h0);
        rq.push_back(64'h8);
        oq.push_back(64'h1111_2222_3333_4444);
        oq.push_back(64'hDEAD_BEEF_0123_4567);
        done_exp  = 1;
        out_ready = 1'b0;
        start_session(3, 10, 2);
        feed(1'b0);
        @(negedge clk);
        chk("in_ready_after_load", 64'(in_ready), 64'(0));
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("out_valid_seen", 64'(out_valid), 64'(1));
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
        finish_session(10);

        // Session B: 2 words with in_valid toggling 1,0,1; no run, no dump.
        pw = '{32'hAAAA_0001, 32'hBBBB_0002};
        wq.push_back('{64'h0, 32'hAAAA_0001, 0});
        wq.push_back('{64'h4, 32'hBBBB_0002, 2});
        done_exp = 1;
        start_session(2, 0, 2'd0);
        feed(1'b1);
        finish_session(0);

        // Session C: everything zero, IDLE -> RUN -> DONE with no strobes.
        pw = {};
        done_exp = 1;
        start_session(0, 0, 0);
        finish_session(0);

        // Session D: reset held 2 cycles mid-RUN aborts with no done and no reads.
        dc = done_cnt;
        start_session(0, 50, 1);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("midrun_enable_before_rst_edge", 64'(cpu_enable), 64'(1));
        @(negedge clk);
        chk("abort_enable", 64'(cpu_enable), 64'(0));
        chk("abort_arst_n", 64'(cpu_arst_n), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (60) @(negedge clk);
        chk("abort_no_done", 64'(done_cnt - dc), 64'(0));
        chk("abort_idle_busy", 64'(busy), 64'(0));

        // Session C again: the block recovers cleanly after an abort.
        done_exp = 1;
        start_session(0, 0, 0);
        finish_session(0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
